// File: rtl/alarm_scheduler_if.sv
// alarm_scheduler_if
//   Groups the alarm scheduler's bus-side signals. The slave modport is the
//   scheduler's view; the master modport is the view of the surrounding
//   logic (time counter, alarm-set bank, buttons, buzzer/LED consumer).
//
//   sec_tick    1   one-cycle pulse per second from the time counter
//   t_hq1       2   current hour tens, BCD
//   t_hq0       4   current hour units, BCD
//   t_mq1       3   current minute tens, BCD
//   t_mq0       4   current minute units, BCD
//   alarm_time  52  slot k at [13k+12:13k] as {hq1, hq0, mq1, mq0}
//   alarm_arm   4   per-slot arm enable
//   stop        1   debounced one-cycle pulse
//   snooze      1   debounced one-cycle pulse
//   ring        1   high while ringing
//   buzz        1   buzzer drive, toggles each second while ringing
//   ring_id     2   slot being served (0 when idle)
//   pending     4   slots queued and not yet served
//   missed      4   sticky per-slot "ring timed out" flags
interface alarm_scheduler_if;
  logic        sec_tick;
  logic [1:0]  t_hq1;
  logic [3:0]  t_hq0;
  logic [2:0]  t_mq1;
  logic [3:0]  t_mq0;
  logic [51:0] alarm_time;
  logic [3:0]  alarm_arm;
  logic        stop;
  logic        snooze;
  logic        ring;
  logic        buzz;
  logic [1:0]  ring_id;
  logic [3:0]  pending;
  logic [3:0]  missed;

  modport slave (
    input  sec_tick, t_hq1, t_hq0, t_mq1, t_mq0, alarm_time, alarm_arm,
           stop, snooze,
    output ring, buzz, ring_id, pending, missed
  );

  modport master (
    output sec_tick, t_hq1, t_hq0, t_mq1, t_mq0, alarm_time, alarm_arm,
           stop, snooze,
    input  ring, buzz, ring_id, pending, missed
  );
endinterface

// File: rtl/alarm_scheduler.sv
// alarm_scheduler
//   Compares the four alarm slots against the running time of day, queues
//   each armed slot once per matching minute, and serves the queue one slot
//   at a time (lowest index first) through ring / snooze / timeout handling.
//
//   clk   system clock
//   clr   synchronous reset, active-low, clears all state
//   bus   alarm_scheduler_if.slave: time, slot bank, arm, stop/snooze and
//         sec_tick in; ring, buzz, ring_id, pending, missed out
module alarm_scheduler #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned SNOOZE_MAX  = 3
) (
  input  logic               clk,
  input  logic               clr,
  alarm_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RING,
    ST_SNOOZE
  } state_t;

  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);
  localparam logic [9:0] SZ_LAST   = 10'(SNOOZE_SECS - 1);
  localparam logic [2:0] SZ_LIMIT  = 3'(SNOOZE_MAX);

  state_t      state_q;
  logic        ring_q;
  logic        buzz_q;
  logic [1:0]  ring_id_q;
  logic [3:0]  pending_q;
  logic [3:0]  pending_d;
  logic [3:0]  missed_q;
  logic [3:0]  match_q;
  logic [7:0]  ring_cnt_q;
  logic [9:0]  sz_timer_q;
  logic [2:0]  snooze_cnt_q;

  logic [12:0] cur_time;
  logic [3:0]  match;
  logic [3:0]  served;
  logic [1:0]  sel;

  always_comb begin
    cur_time = {bus.t_hq1, bus.t_hq0, bus.t_mq1, bus.t_mq0};
    match    = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      match[k] = bus.alarm_arm[k] && (bus.alarm_time[13*k +: 13] == cur_time);
    end
  end

  // Lowest set pending bit wins; scanning downward lets the last hit stick.
  always_comb begin
    sel = '0;
    for (int unsigned k = 4; k > 0; k--) begin
      if (pending_q[k-1]) sel = 2'(k - 1);
    end
  end

  // The slot in service is shielded from disarm-clearing; a fresh match edge
  // is OR-ed in last so a re-trigger during service or selection survives.
  always_comb begin
    served = '0;
    if (state_q != ST_IDLE) served[ring_id_q] = 1'b1;
    pending_d = pending_q & (bus.alarm_arm | served);
    if (state_q == ST_IDLE && pending_q != '0) pending_d[sel] = 1'b0;
    pending_d = pending_d | (match & ~match_q);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q      <= ST_IDLE;
      ring_q       <= 1'b0;
      buzz_q       <= 1'b0;
      ring_id_q    <= '0;
      pending_q    <= '0;
      missed_q     <= '0;
      match_q      <= '0;
      ring_cnt_q   <= '0;
      sz_timer_q   <= '0;
      snooze_cnt_q <= '0;
    end else begin
      match_q   <= match;
      pending_q <= pending_d;
      if (bus.stop) missed_q <= '0;

      case (state_q)
        ST_IDLE: begin
          if (pending_q != '0) begin
            state_q      <= ST_RING;
            ring_q       <= 1'b1;
            buzz_q       <= 1'b1;
            ring_id_q    <= sel;
            ring_cnt_q   <= '0;
            snooze_cnt_q <= '0;
          end
        end

        ST_RING: begin
          if (bus.stop) begin
            state_q   <= ST_IDLE;
            ring_q    <= 1'b0;
            buzz_q    <= 1'b0;
            ring_id_q <= '0;
          end else if (bus.snooze && snooze_cnt_q < SZ_LIMIT) begin
            state_q      <= ST_SNOOZE;
            ring_q       <= 1'b0;
            buzz_q       <= 1'b0;
            snooze_cnt_q <= snooze_cnt_q + 3'd1;
            sz_timer_q   <= '0;
          end else if (bus.sec_tick) begin
            if (ring_cnt_q == RING_LAST) begin
              state_q             <= ST_IDLE;
              ring_q              <= 1'b0;
              buzz_q              <= 1'b0;
              missed_q[ring_id_q] <= 1'b1;
              ring_id_q           <= '0;
            end else begin
              buzz_q     <= ~buzz_q;
              ring_cnt_q <= ring_cnt_q + 8'd1;
            end
          end
        end

        ST_SNOOZE: begin
          if (bus.stop) begin
            state_q   <= ST_IDLE;
            ring_id_q <= '0;
          end else if (bus.sec_tick) begin
            if (sz_timer_q == SZ_LAST) begin
              state_q    <= ST_RING;
              ring_q     <= 1'b1;
              buzz_q     <= 1'b1;
              ring_cnt_q <= '0;
            end else begin
              sz_timer_q <= sz_timer_q + 10'd1;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ring    = ring_q;
  assign bus.buzz    = buzz_q;
  assign bus.ring_id = ring_id_q;
  assign bus.pending = pending_q;
  assign bus.missed  = missed_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// tb_alarm_scheduler
//   Directed sequence followed by randomized traffic for alarm_scheduler,
//   checked every cycle against a countdown-based reference model.
module tb_alarm_scheduler;

  localparam int RS = 5;
  localparam int SS = 4;
  localparam int SM = 2;

  logic clk = 1'b0;
  logic clr = 1'b0;

  alarm_scheduler_if bus ();

  alarm_scheduler #(
    .RING_SECS  (RS),
    .SNOOZE_SECS(SS),
    .SNOOZE_MAX (SM)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: countdowns of seconds left, not up-counters.
  bit       m_ringing  = 0;
  bit       m_snoozing = 0;
  bit       m_buzz     = 0;
  int       m_id       = 0;
  int       m_left     = 0;
  int       m_used     = 0;
  bit [3:0] m_pend     = '0;
  bit [3:0] m_missed   = '0;
  bit [3:0] m_prev     = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [12:0] tm(input int h, input int m);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
  endfunction

  task automatic set_time_v(input logic [12:0] v);
    bus.t_hq1 = v[12:11];
    bus.t_hq0 = v[10:7];
    bus.t_mq1 = v[6:4];
    bus.t_mq0 = v[3:0];
  endtask

  task automatic set_time(input int h, input int m);
    set_time_v(tm(h, m));
  endtask

  task automatic set_slot(input int k, input logic [12:0] v);
    bus.alarm_time[13*k +: 13] = v;
  endtask

  task automatic model_step();
    logic [12:0] cur;
    bit   [3:0]  match;
    bit   [3:0]  np;
    bit          serving;
    int          sel;
    if (!clr) begin
      m_ringing = 0; m_snoozing = 0; m_buzz = 0; m_id = 0; m_left = 0;
      m_used = 0; m_pend = '0; m_missed = '0; m_prev = '0;
      return;
    end
    cur = {bus.t_hq1, bus.t_hq0, bus.t_mq1, bus.t_mq0};
    for (int k = 0; k < 4; k++)
      match[k] = bus.alarm_arm[k] && (bus.alarm_time[13*k +: 13] == cur);
    serving = m_ringing || m_snoozing;
    np = m_pend;
    for (int k = 0; k < 4; k++)
      if (!bus.alarm_arm[k] && !(serving && m_id == k)) np[k] = 0;
    if (bus.stop) m_missed = '0;
    if (!serving) begin
      if (m_pend != 0) begin
        sel = 0;
        while (!m_pend[sel]) sel++;
        np[sel] = 0;
        m_ringing = 1; m_id = sel; m_left = RS; m_buzz = 1; m_used = 0;
      end
    end else if (m_ringing) begin
      if (bus.stop) begin
        m_ringing = 0; m_buzz = 0; m_id = 0;
      end else if (bus.snooze && m_used < SM) begin
        m_ringing = 0; m_snoozing = 1; m_used++; m_left = SS; m_buzz = 0;
      end else if (bus.sec_tick) begin
        m_left--;
        if (m_left == 0) begin
          m_ringing = 0; m_buzz = 0; m_missed[m_id] = 1; m_id = 0;
        end else begin
          m_buzz = !m_buzz;
        end
      end
    end else begin
      if (bus.stop) begin
        m_snoozing = 0; m_id = 0;
      end else if (bus.sec_tick) begin
        m_left--;
        if (m_left == 0) begin
          m_snoozing = 0; m_ringing = 1; m_left = RS; m_buzz = 1;
        end
      end
    end
    m_pend = np | (match & ~m_prev);
    m_prev = match;
  endtask

  // One clock: model consumes the inputs the DUT samples, then outputs are
  // compared 1 time unit after the edge and the one-cycle pulses drop.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("ring",    32'(bus.ring),    32'(m_ringing));
    chk("buzz",    32'(bus.buzz),    32'(m_buzz));
    chk("ring_id", 32'(bus.ring_id), 32'(m_id));
    chk("pending", 32'(bus.pending), 32'(m_pend));
    chk("missed",  32'(bus.missed),  32'(m_missed));
    bus.stop     = 1'b0;
    bus.snooze   = 1'b0;
    bus.sec_tick = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic tick();
    bus.sec_tick = 1'b1;
    cycle();
    cycle();
  endtask

  logic [12:0] topt [4];

  initial begin
    bus.sec_tick = 1'b0; bus.stop = 1'b0; bus.snooze = 1'b0;
    bus.alarm_time = '0;
    set_slot(0, tm(9, 0));
    set_slot(1, tm(12, 0));
    set_slot(2, tm(7, 30));
    set_slot(3, tm(12, 0));
    set_time(9, 0);
    bus.alarm_arm = 4'hF;
    clr = 1'b0;

    // Reset held with slot 0 matching
    cycles(3);
    chk("rst_ring",    32'(bus.ring),    0);
    chk("rst_buzz",    32'(bus.buzz),    0);
    chk("rst_pending", 32'(bus.pending), 0);
    chk("rst_missed",  32'(bus.missed),  0);
    clr = 1'b1;
    cycle();
    chk("rel_pending", 32'(bus.pending), 32'h1);
    cycle();
    chk("rel_ring", 32'(bus.ring), 1);
    bus.stop = 1'b1;
    cycle();
    chk("rel_stop", 32'(bus.ring), 0);

    // Single alarm, slot 2 at 07:30
    bus.alarm_arm = 4'b0100;
    set_time(7, 29);
    cycles(2);
    set_time(7, 30);
    cycle();
    chk("s_pending", 32'(bus.pending), 32'h4);
    cycle();
    chk("s_ring", 32'(bus.ring), 1);
    chk("s_id",   32'(bus.ring_id), 2);
    chk("s_buzz0", 32'(bus.buzz), 1);
    tick();
    chk("s_buzz1", 32'(bus.buzz), 0);
    tick();
    chk("s_buzz2", 32'(bus.buzz), 1);
    bus.stop = 1'b1;
    cycle();
    chk("s_stop", 32'(bus.ring), 0);
    cycles(3);
    chk("s_noretrig", 32'(bus.ring), 0);

    // Slots 1 and 3 both at 12:00
    bus.alarm_arm = 4'b1010;
    set_time(11, 59);
    cycles(2);
    set_time(12, 0);
    cycle();
    chk("m_pending", 32'(bus.pending), 32'hA);
    cycle();
    chk("m_id1",  32'(bus.ring_id), 1);
    chk("m_pend3", 32'(bus.pending), 32'h8);
    bus.stop = 1'b1;
    cycle();
    cycle();
    chk("m_id3", 32'(bus.ring_id), 3);
    chk("m_ring3", 32'(bus.ring), 1);
    bus.stop = 1'b1;
    cycle();

    // Snooze limit
    bus.alarm_arm = 4'b0100;
    set_time(7, 30);
    cycles(2);
    chk("z_ring", 32'(bus.ring), 1);
    for (int r = 0; r < SM; r++) begin
      bus.snooze = 1'b1;
      cycle();
      chk("z_snoozed", 32'(bus.ring), 0);
      chk("z_snz_id",  32'(bus.ring_id), 2);
      repeat (SS - 1) tick();
      chk("z_still_snz", 32'(bus.ring), 0);
      tick();
      chk("z_rering", 32'(bus.ring), 1);
      chk("z_rebuzz", 32'(bus.buzz), 1);
    end
    bus.snooze = 1'b1;
    cycle();
    chk("z_ignored", 32'(bus.ring), 1);
    tick();
    tick();
    chk("z_persist", 32'(bus.ring), 1);
    bus.stop = 1'b1;
    cycle();
    chk("z_stop", 32'(bus.ring), 0);

    // Timeout on slot 0
    bus.alarm_arm = 4'b0001;
    set_time(9, 0);
    cycles(2);
    chk("t_ring", 32'(bus.ring), 1);
    repeat (RS - 1) tick();
    chk("t_before", 32'(bus.ring), 1);
    bus.sec_tick = 1'b1;
    cycle();
    chk("t_timeout", 32'(bus.ring), 0);
    chk("t_missed",  32'(bus.missed), 32'h1);
    cycle();
    bus.stop = 1'b1;
    cycle();
    chk("t_clear", 32'(bus.missed), 0);

    // Reset during snooze, time still matching slot 0
    bus.alarm_arm = 4'b0000;
    cycle();
    bus.alarm_arm = 4'b0001;
    cycles(2);
    chk("r_ring", 32'(bus.ring), 1);
    bus.snooze = 1'b1;
    cycle();
    clr = 1'b0;
    cycle();
    chk("r_idle_id",   32'(bus.ring_id), 0);
    chk("r_idle_pend", 32'(bus.pending), 0);
    clr = 1'b1;
    cycle();
    chk("r_repend", 32'(bus.pending), 32'h1);
    cycle();
    chk("r_rering", 32'(bus.ring), 1);
    bus.stop = 1'b1;
    cycle();

    // Randomized traffic
    topt[0] = tm(7, 30);
    topt[1] = tm(7, 31);
    topt[2] = tm(12, 0);
    topt[3] = tm(9, 0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) set_time_v(topt[$urandom_range(0, 3)]);
      if ($urandom_range(0, 199) == 0) set_slot($urandom_range(0, 3), topt[$urandom_range(0, 3)]);
      if ($urandom_range(0, 7) == 0) bus.alarm_arm[$urandom_range(0, 3)] = ~bus.alarm_arm[$urandom_range(0, 3)];
      bus.stop     = ($urandom_range(0, 24) == 0);
      bus.snooze   = ($urandom_range(0, 11) == 0);
      bus.sec_tick = ($urandom_range(0, 2) == 0);
      clr          = ($urandom_range(0, 299) != 0);
      cycle();
    end
    clr = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
